// File: rtl/sync_fifo_pkg.sv
// Sizing helpers and default geometry shared by the FIFO controller and its RAM.
package sync_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 4;
    localparam int DEF_ADDR_DEPTH = 128;

    // Bits needed to represent value (clogb2(7) = 3, clogb2(127) = 7).
    function automatic int clogb2(input int value);
        int bits;
        bits = 0;
        for (int i = 0; i < 31; i++) begin
            if ((value >> i) > 0) bits = i + 1;
        end
        return bits;
    endfunction

    localparam int DEF_AW = clogb2(DEF_ADDR_DEPTH - 1);
    localparam int DEF_CW = DEF_AW + 1;

endpackage

// File: rtl/sync_fifo_ctrl.sv
// FIFO controller in front of a simple dual-port RAM: pointers, occupancy,
// registered flags, error pulses and a valid-qualified read stream.
module sync_fifo_ctrl
    import sync_fifo_pkg::*;
#(
    parameter int P_DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int P_ADDR_DEPTH = DEF_ADDR_DEPTH,
    parameter int P_AFULL      = P_ADDR_DEPTH - 2,
    parameter int P_AEMPTY     = 2,
    localparam int AW          = clogb2(P_ADDR_DEPTH - 1),
    localparam int CW          = AW + 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_wr_en,
    input  logic [P_DATA_WIDTH-1:0] i_wr_data,
    input  logic                    i_rd_en,
    output logic [P_DATA_WIDTH-1:0] o_rd_data,
    output logic                    o_rd_valid,
    output logic                    o_full,
    output logic                    o_empty,
    output logic                    o_almost_full,
    output logic                    o_almost_empty,
    output logic [AW:0]             o_data_cnt,
    output logic                    o_overflow,
    output logic                    o_underflow,
    output logic                    o_ram_ena,
    output logic                    o_ram_enb,
    output logic [AW-1:0]           o_ram_waddr,
    output logic [AW-1:0]           o_ram_raddr,
    output logic [P_DATA_WIDTH-1:0] o_ram_wdata,
    input  logic [P_DATA_WIDTH-1:0] i_ram_rdata
);

    localparam logic [CW-1:0] DEPTH_C  = CW'(P_ADDR_DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(P_AFULL);
    localparam logic [CW-1:0] AEMPTY_C = CW'(P_AEMPTY);

    logic [AW:0]   wptr_q;
    logic [AW:0]   rptr_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_next;
    logic          full_q;
    logic          empty_q;
    logic          afull_q;
    logic          aempty_q;
    logic          rd_valid_q;
    logic          overflow_q;
    logic          underflow_q;
    logic          push_ok;
    logic          pop_ok;

    // Gating with i_rst keeps the RAM idle for as long as reset is held,
    // including the first edge when the flags are not yet initialised.
    assign push_ok = i_rst & i_wr_en & ~full_q;
    assign pop_ok  = i_rst & i_rd_en & ~empty_q;

    assign o_ram_ena   = push_ok;
    assign o_ram_waddr = wptr_q[AW-1:0];
    assign o_ram_wdata = i_wr_data;
    assign o_ram_enb   = pop_ok;
    assign o_ram_raddr = rptr_q[AW-1:0];

    always_comb begin
        cnt_next = cnt_q;
        case ({push_ok, pop_ok})
            2'b10:   cnt_next = cnt_q + CW'(1);
            2'b01:   cnt_next = cnt_q - CW'(1);
            default: cnt_next = cnt_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            afull_q     <= 1'b0;
            aempty_q    <= 1'b1;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + (AW+1)'(1);
            if (pop_ok)  rptr_q <= rptr_q + (AW+1)'(1);
            cnt_q       <= cnt_next;
            full_q      <= (cnt_next == DEPTH_C);
            empty_q     <= (cnt_next == '0);
            afull_q     <= (cnt_next >= AFULL_C);
            aempty_q    <= (cnt_next <= AEMPTY_C);
            // RAM read data arrives one cycle after the accepted pop.
            rd_valid_q  <= pop_ok;
            overflow_q  <= i_wr_en & full_q;
            underflow_q <= i_rd_en & empty_q;
        end
    end

    assign o_rd_data      = i_ram_rdata;
    assign o_rd_valid     = rd_valid_q;
    assign o_full         = full_q;
    assign o_empty        = empty_q;
    assign o_almost_full  = afull_q;
    assign o_almost_empty = aempty_q;
    assign o_data_cnt     = cnt_q;
    assign o_overflow     = overflow_q;
    assign o_underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: depth-8 instance with a behavioural RAM, a queue
// reference model, a fill/drain vector table and directed corner sequences.
module tb_sync_fifo_ctrl;

    localparam int DEPTH = 8;
    localparam int DW    = 4;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic          afull;
    logic          aempty;
    logic [3:0]    data_cnt;
    logic          ovf;
    logic          udf;
    logic          ram_ena;
    logic          ram_enb;
    logic [2:0]    ram_waddr;
    logic [2:0]    ram_raddr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    sync_fifo_ctrl #(
        .P_DATA_WIDTH(DW),
        .P_ADDR_DEPTH(DEPTH),
        .P_AFULL(6),
        .P_AEMPTY(2)
    ) dut (
        .i_clk(clk),
        .i_rst(rst_n),
        .i_wr_en(wr_en),
        .i_wr_data(wr_data),
        .i_rd_en(rd_en),
        .o_rd_data(rd_data),
        .o_rd_valid(rd_valid),
        .o_full(full),
        .o_empty(empty),
        .o_almost_full(afull),
        .o_almost_empty(aempty),
        .o_data_cnt(data_cnt),
        .o_overflow(ovf),
        .o_underflow(udf),
        .o_ram_ena(ram_ena),
        .o_ram_enb(ram_enb),
        .o_ram_waddr(ram_waddr),
        .o_ram_raddr(ram_raddr),
        .o_ram_wdata(ram_wdata),
        .i_ram_rdata(ram_rdata)
    );

    // Simple dual-port RAM with registered read.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_ena) mem[ram_waddr] <= ram_wdata;
        if (ram_enb) ram_rdata <= mem[ram_raddr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before the test finished");
        $fatal(1, "watchdog");
    end

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [DW-1:0] mq[$];
    int            wcount = 0;
    int            rcount = 0;
    logic          m_valid = 0;
    logic [DW-1:0] m_data = 0;
    logic          m_ovf = 0;
    logic          m_udf = 0;
    logic [2:0]    waddr_seen;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic wr, input logic [DW-1:0] wd, input logic rd,
                         input logic rst, output logic ena_seen);
        logic pacc, racc;
        int   sz;
        wr_en = wr; wr_data = wd; rd_en = rd; rst_n = rst;
        #1;
        sz   = mq.size();
        pacc = rst && wr && (sz < DEPTH);
        racc = rst && rd && (sz > 0);
        ena_seen   = ram_ena;
        waddr_seen = ram_waddr;
        chk("ram_ena", {31'd0, ram_ena}, {31'd0, pacc});
        chk("ram_enb", {31'd0, ram_enb}, {31'd0, racc});
        if (rst) begin
            chk("ram_waddr", {29'd0, ram_waddr}, wcount % DEPTH);
            chk("ram_raddr", {29'd0, ram_raddr}, rcount % DEPTH);
            if (pacc) chk("ram_wdata", {28'd0, ram_wdata}, {28'd0, wd});
        end
        @(posedge clk);
        #1;
        if (!rst) begin
            mq.delete();
            wcount = 0; rcount = 0;
            m_valid = 0; m_ovf = 0; m_udf = 0;
        end else begin
            m_valid = racc;
            if (racc) begin
                m_data = mq.pop_front();
                rcount++;
            end
            if (pacc) begin
                mq.push_back(wd);
                wcount++;
            end
            m_ovf = wr && (sz == DEPTH);
            m_udf = rd && (sz == 0);
        end
        chk("data_cnt", {28'd0, data_cnt}, mq.size());
        chk("full", {31'd0, full}, {31'd0, mq.size() == DEPTH});
        chk("empty", {31'd0, empty}, {31'd0, mq.size() == 0});
        chk("almost_full", {31'd0, afull}, {31'd0, mq.size() >= 6});
        chk("almost_empty", {31'd0, aempty}, {31'd0, mq.size() <= 2});
        chk("rd_valid", {31'd0, rd_valid}, {31'd0, m_valid});
        if (m_valid) chk("rd_data", {28'd0, rd_data}, {28'd0, m_data});
        chk("overflow", {31'd0, ovf}, {31'd0, m_ovf});
        chk("underflow", {31'd0, udf}, {31'd0, m_udf});
    endtask

    typedef struct {
        logic          wr;
        logic [DW-1:0] wd;
        logic          rd;
        logic          ena;
        logic [3:0]    cnt;
        logic          full;
        logic          empty;
        logic          afull;
        logic          aempty;
        logic          valid;
        logic [DW-1:0] data;
        logic          ovf;
        logic          udf;
    } vec_t;

    function automatic vec_t mkvec(input logic wr, input int wd, input logic rd, input logic ena,
                                   input int cnt, input logic vld, input int data,
                                   input logic o, input logic u);
        vec_t v;
        v.wr = wr; v.wd = DW'(wd); v.rd = rd; v.ena = ena;
        v.cnt = 4'(cnt);
        v.full = (cnt == 8); v.empty = (cnt == 0);
        v.afull = (cnt >= 6); v.aempty = (cnt <= 2);
        v.valid = vld; v.data = DW'(data); v.ovf = o; v.udf = u;
        return v;
    endfunction

    vec_t vt[$];

    initial begin
        logic          ena;
        logic [DW-1:0] all_in[$];
        logic          saw_wrap;
        logic [2:0]    prev_waddr;

        // Fill 1..8, rejected 9th push, idle, drain 8, rejected pop, idle.
        for (int k = 1; k <= 8; k++) vt.push_back(mkvec(1, k, 0, 1, k, 0, 0, 0, 0));
        vt.push_back(mkvec(1, 9, 0, 0, 8, 0, 0, 1, 0));
        vt.push_back(mkvec(0, 0, 0, 0, 8, 0, 0, 0, 0));
        for (int j = 1; j <= 8; j++) vt.push_back(mkvec(0, 0, 1, 0, 8 - j, 1, j, 0, 0));
        vt.push_back(mkvec(0, 0, 1, 0, 0, 0, 0, 0, 1));
        vt.push_back(mkvec(0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Reset held two cycles, requests asserted during the second.
        cycle(0, 0, 0, 0, ena);
        cycle(1, 4'h3, 1, 0, ena);
        chk("rst_empty", {31'd0, empty}, 1);
        chk("rst_aempty", {31'd0, aempty}, 1);
        chk("rst_cnt", {28'd0, data_cnt}, 0);
        chk("rst_valid", {31'd0, rd_valid}, 0);

        for (int i = 0; i < vt.size(); i++) begin
            cycle(vt[i].wr, vt[i].wd, vt[i].rd, 1, ena);
            chk($sformatf("vec%0d_ena", i), {31'd0, ena}, {31'd0, vt[i].ena});
            chk($sformatf("vec%0d_cnt", i), {28'd0, data_cnt}, {28'd0, vt[i].cnt});
            chk($sformatf("vec%0d_full", i), {31'd0, full}, {31'd0, vt[i].full});
            chk($sformatf("vec%0d_empty", i), {31'd0, empty}, {31'd0, vt[i].empty});
            chk($sformatf("vec%0d_afull", i), {31'd0, afull}, {31'd0, vt[i].afull});
            chk($sformatf("vec%0d_aempty", i), {31'd0, aempty}, {31'd0, vt[i].aempty});
            chk($sformatf("vec%0d_valid", i), {31'd0, rd_valid}, {31'd0, vt[i].valid});
            if (vt[i].valid) chk($sformatf("vec%0d_data", i), {28'd0, rd_data}, {28'd0, vt[i].data});
            chk($sformatf("vec%0d_ovf", i), {31'd0, ovf}, {31'd0, vt[i].ovf});
            chk($sformatf("vec%0d_udf", i), {31'd0, udf}, {31'd0, vt[i].udf});
        end

        // Streaming at count 4 across the address wrap.
        for (int i = 0; i < 4; i++) begin
            all_in.push_back(DW'($urandom));
            cycle(1, all_in[i], 0, 1, ena);
        end
        saw_wrap = 0;
        prev_waddr = 3'd0;
        for (int i = 0; i < 20; i++) begin
            all_in.push_back(DW'($urandom));
            cycle(1, all_in[i + 4], 1, 1, ena);
            if (i > 0 && prev_waddr == 3'd7 && waddr_seen == 3'd0) saw_wrap = 1;
            prev_waddr = waddr_seen;
            chk("stream_cnt", {28'd0, data_cnt}, 4);
            chk("stream_valid", {31'd0, rd_valid}, 1);
            chk("stream_order", {28'd0, rd_data}, {28'd0, all_in[i]});
        end
        chk("stream_waddr_wrap", {31'd0, saw_wrap}, 1);

        // Simultaneous push and pop at full, then at empty.
        while (mq.size() > 0) cycle(0, 0, 1, 1, ena);
        for (int i = 0; i < DEPTH; i++) cycle(1, DW'(i + 5), 0, 1, ena);
        cycle(1, 4'hF, 1, 1, ena);
        chk("full_both_ovf", {31'd0, ovf}, 1);
        chk("full_both_cnt", {28'd0, data_cnt}, 7);
        chk("full_both_ena", {31'd0, ena}, 0);
        for (int i = 0; i < 7; i++) cycle(0, 0, 1, 1, ena);
        cycle(0, 0, 0, 1, ena);
        cycle(1, 4'hC, 1, 1, ena);
        chk("empty_both_udf", {31'd0, udf}, 1);
        chk("empty_both_cnt", {28'd0, data_cnt}, 1);
        chk("empty_both_ena", {31'd0, ena}, 1);
        cycle(0, 0, 1, 1, ena);
        chk("empty_both_data", {28'd0, rd_data}, 4'hC);

        // Reset arriving together with a pop at count 5.
        for (int i = 0; i < 5; i++) cycle(1, DW'(i + 1), 0, 1, ena);
        cycle(0, 0, 1, 0, ena);
        chk("midrst_valid", {31'd0, rd_valid}, 0);
        chk("midrst_empty", {31'd0, empty}, 1);
        chk("midrst_cnt", {28'd0, data_cnt}, 0);
        cycle(1, 4'hA, 0, 1, ena);
        cycle(0, 0, 1, 1, ena);
        chk("midrst_pop_valid", {31'd0, rd_valid}, 1);
        chk("midrst_pop_data", {28'd0, rd_data}, 4'hA);
        cycle(0, 0, 0, 1, ena);

        // Randomised traffic: push-heavy, then pop-heavy, with rare resets.
        for (int i = 0; i < 600; i++) begin
            logic r_wr, r_rd, r_rst;
            if (i < 300) begin
                r_wr = ($urandom_range(0, 99) < 70);
                r_rd = ($urandom_range(0, 99) < 35);
            end else begin
                r_wr = ($urandom_range(0, 99) < 35);
                r_rd = ($urandom_range(0, 99) < 70);
            end
            r_rst = ($urandom_range(0, 79) != 0);
            cycle(r_wr, DW'($urandom), r_rd, r_rst, ena);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_fifo_ctrl.md
# sync_fifo_ctrl

Synchronous FIFO controller that sits directly upstream of the team's simple dual-port RAM and drives its write/read enables, addresses and write data. It turns the RAM into a first-in-first-out buffer. It owns the pointers, occupancy count and flags, and the push/pop handshake. It also re-times the RAM's one-cycle registered read into a valid-qualified output stream.

## Interface
- P_DATA_WIDTH, 4, word width
- P_ADDR_DEPTH, 128, RAM depth in words; power of two, ≥4
- P_AFULL, P_ADDR_DEPTH-2, almost-full threshold (count ≥ P_AFULL)
- P_AEMPTY, 2, almost-empty threshold (count ≤ P_AEMPTY)
- i_clk  in  1  sole clock, all logic on rising edge
- i_rst  in  1  reset; synchronous, active-low
- i_wr_en  in  1  push request
- i_wr_data  in  P_DATA_WIDTH  push data
- i_rd_en  in  1  pop request
- o_rd_data  out  P_DATA_WIDTH  popped word, meaningful only when o_rd_valid=1
- o_rd_valid  out  1  popped word present this cycle
- o_full / o_empty  out  1  occupancy flags
- o_almost_full / o_almost_empty  out  1  threshold flags
- o_data_cnt  out  AW+1  words stored, 0..P_ADDR_DEPTH (AW = clogb2(P_ADDR_DEPTH-1))
- o_overflow / o_underflow  out  1  one-cycle pulse on a rejected push/pop
- o_ram_ena  out  1  RAM write enable
- o_ram_enb  out  1  RAM read enable
- o_ram_waddr, o_ram_raddr  out  AW  RAM addresses
- o_ram_wdata  out  P_DATA_WIDTH  RAM write data
- i_ram_rdata  in  P_DATA_WIDTH  RAM registered read data

## Operation
- State: write pointer, read pointer (AW+1 bits, MSB = wrap bit), count register, rd_valid register, overflow/underflow registers.
- Accept rules use the registered flags only:
  - push_ok = i_wr_en & ~o_full
  - pop_ok = i_rd_en & ~o_empty
- RAM drive is combinational:
  - o_ram_ena = push_ok; o_ram_waddr = wptr[AW-1:0]; o_ram_wdata = i_wr_data
  - o_ram_enb = pop_ok; o_ram_raddr = rptr[AW-1:0]
- Pointers: push_ok → wptr+1; pop_ok → rptr+1. Both wrap naturally modulo 2·P_ADDR_DEPTH.
- Count: +1 on push only, −1 on pop only, unchanged on both or neither.
- Flags are registered and computed from the next count:
  - full = (cnt_next == P_ADDR_DEPTH); empty = (cnt_next == 0)
  - almost_full = (cnt_next ≥ P_AFULL); almost_empty = (cnt_next ≤ P_AEMPTY)
- Push and pop in the same cycle:
  - Full: the pop is accepted and the push is rejected. o_overflow pulses and the count drops by 1.
  - Empty: the push is accepted and the pop is rejected. o_underflow pulses and the count rises by 1.
  - Otherwise both are accepted and the count is unchanged.
- A rejected request changes no state apart from its error pulse.
- o_rd_data = i_ram_rdata, passed straight through. No extra register.
- RAM contents never need clearing: only written addresses are ever read.

## Timing
- Reset (i_rst=0 at an edge) forces:
  - wptr=rptr=0, count=0
  - o_empty=1, o_almost_empty=1, o_full=0, o_almost_full=0
  - o_rd_valid=0, o_overflow=0, o_underflow=0
  - Combinational RAM enables are 0 for the whole time reset is held.
- Reset mid-operation: the next edge clears all state. A read in flight does not produce o_rd_valid.
- Pop latency: pop_ok at edge N → o_rd_valid=1 and the word on o_rd_data during cycle N+1.
  - Back-to-back pops give one word per cycle, in write order.
- Flag latency: flags and o_data_cnt reflect an accepted push/pop one cycle after its edge.
- Write-to-read: a word pushed at edge N can be popped at edge N+1 at the earliest, because empty deasserts after edge N.
- Error pulses are registered and last exactly one cycle per rejected request.

## Structure
- Shared package holds:
  - the clogb2 function
  - AW and count-width localparams
  - default depth and width constants, shared with the RAM instance
- No internal sub-module. The integration wrapper sync_fifo instantiates sync_fifo_ctrl plus the dual-port RAM; the RAM reset there is tied to ~i_rst.

## Test plan
Bench configuration: P_ADDR_DEPTH=8, P_DATA_WIDTH=4, P_AFULL=6, P_AEMPTY=2.

- Reset: hold i_rst=0 for 2 cycles → o_empty=1, o_almost_empty=1, o_data_cnt=0, o_rd_valid=0, both RAM enables 0.
- Fill: push 0x1..0x8 on consecutive cycles.
  - o_almost_empty drops after the 3rd push; o_almost_full rises after the 6th.
  - o_full=1 and o_data_cnt=8 after the 8th.
  - A 9th push gives o_overflow=1 for one cycle, count stays 8, o_ram_ena=0.
- Drain: pop 8 times.
  - o_rd_valid is high one cycle after each pop, with data 0x1..0x8 in order.
  - o_empty=1 after the last pop.
  - An extra pop gives o_underflow=1 and no o_rd_valid.
- Streaming wrap: at count=4, push and pop every cycle for 20 cycles.
  - Count stays 4; o_ram_waddr wraps 7→0.
  - Output sequence equals input sequence delayed by 4 words.
- Boundary simultaneity:
  - At full, push+pop → pop accepted, o_overflow=1, count=7.
  - At empty, push+pop → push accepted, o_underflow=1, count=1.
- Reset mid-operation: at count=5, pop issued in the same cycle as i_rst=0.
  - Next cycle: o_rd_valid=0, o_empty=1, count=0.
  - A new push 0xA then pop returns 0xA.
